// File: rtl/mmu_tlb_nch.sv
// Shared kseg MMU: direct-maps kseg0/kseg1, translates the rest through a fully-associative 4KB-page TLB.
// Each channel has a 1-cycle registered lookup with valid/ready, and all channels search the same entry array.
module mmu_tlb_nch #(
  parameter int NCH     = 2,
  parameter int IDXW    = 4,
  parameter int MAP_ALL = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_cur_asid,
  input  logic [NCH-1:0]    i_req_valid,
  output logic [NCH-1:0]    o_req_ready,
  input  logic [NCH*32-1:0] i_req_vaddr,
  input  logic [NCH-1:0]    i_req_store,
  output logic [NCH-1:0]    o_resp_valid,
  input  logic [NCH-1:0]    i_resp_ready,
  output logic [NCH*32-1:0] o_resp_paddr,
  output logic [NCH-1:0]    o_resp_uncached,
  output logic [NCH-1:0]    o_resp_miss,
  output logic [NCH-1:0]    o_resp_inv,
  output logic [NCH-1:0]    o_resp_mod,
  input  logic              i_tlbw_en,
  input  logic [IDXW-1:0]   i_tlbw_idx,
  input  logic [19:0]       i_tlbw_vpn,
  input  logic [19:0]       i_tlbw_pfn,
  input  logic [7:0]        i_tlbw_asid,
  input  logic              i_tlbw_g,
  input  logic              i_tlbw_v,
  input  logic              i_tlbw_d,
  input  logic              i_tlb_flush
);

  localparam int ENTRIES   = 1 << IDXW;
  localparam bit DIRECT_EN = (MAP_ALL == 0);

  logic [ENTRIES-1:0] r_present;
  logic [19:0]        r_vpn  [ENTRIES];
  logic [19:0]        r_pfn  [ENTRIES];
  logic [7:0]         r_asid [ENTRIES];
  logic [ENTRIES-1:0] r_g;
  logic [ENTRIES-1:0] r_v;
  logic [ENTRIES-1:0] r_d;

  // A write in the same cycle as a flush re-marks its own index present.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_present <= '0;
    end else begin
      if (i_tlb_flush) r_present <= '0;
      if (i_tlbw_en)   r_present[i_tlbw_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_tlbw_en) begin
      r_vpn[i_tlbw_idx]  <= i_tlbw_vpn;
      r_pfn[i_tlbw_idx]  <= i_tlbw_pfn;
      r_asid[i_tlbw_idx] <= i_tlbw_asid;
      r_g[i_tlbw_idx]    <= i_tlbw_g;
      r_v[i_tlbw_idx]    <= i_tlbw_v;
      r_d[i_tlbw_idx]    <= i_tlbw_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [31:0]     w_va;
    logic            w_direct;
    logic            w_hit;
    logic [IDXW-1:0] w_idx;
    logic            w_fire;
    logic [31:0]     w_pa;
    logic            w_unc;
    logic            w_miss;
    logic            w_inv;
    logic            w_mod;
    logic            r_vld;
    logic [31:0]     r_pa;
    logic            r_unc;
    logic            r_miss;
    logic            r_inv;
    logic            r_mod;

    assign w_va     = i_req_vaddr[32*c +: 32];
    assign w_direct = DIRECT_EN && (w_va[31:30] == 2'b10);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      for (int e = ENTRIES - 1; e >= 0; e--) begin
        if (r_present[e] && (r_vpn[e] == w_va[31:12]) &&
            (r_g[e] || (r_asid[e] == i_cur_asid))) begin
          w_hit = 1'b1;
          w_idx = e[IDXW-1:0];
        end
      end
    end

    always_comb begin
      w_pa   = '0;
      w_unc  = 1'b0;
      w_miss = 1'b0;
      w_inv  = 1'b0;
      w_mod  = 1'b0;
      if (w_direct) begin
        w_pa  = {3'b000, w_va[28:0]};
        w_unc = w_va[29];
      end else if (w_hit) begin
        w_pa  = {r_pfn[w_idx], w_va[11:0]};
        w_inv = ~r_v[w_idx];
        w_mod = r_v[w_idx] & i_req_store[c] & ~r_d[w_idx];
      end else begin
        w_miss = 1'b1;
      end
    end

    assign o_req_ready[c] = ~r_vld | i_resp_ready[c];
    assign w_fire         = i_req_valid[c] & o_req_ready[c];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld  <= 1'b0;
        r_pa   <= '0;
        r_unc  <= 1'b0;
        r_miss <= 1'b0;
        r_inv  <= 1'b0;
        r_mod  <= 1'b0;
      end else if (w_fire) begin
        r_vld  <= 1'b1;
        r_pa   <= w_pa;
        r_unc  <= w_unc;
        r_miss <= w_miss;
        r_inv  <= w_inv;
        r_mod  <= w_mod;
      end else if (i_resp_ready[c]) begin
        r_vld  <= 1'b0;
      end
    end

    assign o_resp_valid[c]         = r_vld;
    assign o_resp_paddr[32*c +: 32] = r_pa;
    assign o_resp_uncached[c]      = r_unc;
    assign o_resp_miss[c]          = r_miss;
    assign o_resp_inv[c]           = r_inv;
    assign o_resp_mod[c]           = r_mod;
  end

endmodule

// File: tb/tb_mmu_tlb_nch.sv
// Bench for mmu_tlb_nch: directed scenarios plus random traffic against a behavioural TLB/handshake model.
module tb_mmu_tlb_nch;
  localparam int NCH  = 2;
  localparam int IDXW = 4;
  localparam int ENT  = 1 << IDXW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [7:0]        cur_asid;
  logic [NCH-1:0]    req_valid, req_ready, req_store;
  logic [NCH*32-1:0] req_vaddr;
  logic [NCH-1:0]    resp_valid, resp_ready, resp_uncached, resp_miss, resp_inv, resp_mod;
  logic [NCH*32-1:0] resp_paddr;
  logic              tlbw_en, tlbw_g, tlbw_v, tlbw_d, tlb_flush;
  logic [IDXW-1:0]   tlbw_idx;
  logic [19:0]       tlbw_vpn, tlbw_pfn;
  logic [7:0]        tlbw_asid;

  mmu_tlb_nch #(.NCH(NCH), .IDXW(IDXW), .MAP_ALL(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_cur_asid(cur_asid),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_vaddr(req_vaddr),
    .i_req_store(req_store), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_paddr(resp_paddr), .o_resp_uncached(resp_uncached), .o_resp_miss(resp_miss),
    .o_resp_inv(resp_inv), .o_resp_mod(resp_mod),
    .i_tlbw_en(tlbw_en), .i_tlbw_idx(tlbw_idx), .i_tlbw_vpn(tlbw_vpn), .i_tlbw_pfn(tlbw_pfn),
    .i_tlbw_asid(tlbw_asid), .i_tlbw_g(tlbw_g), .i_tlbw_v(tlbw_v), .i_tlbw_d(tlbw_d),
    .i_tlb_flush(tlb_flush)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference TLB contents and expected per-channel response registers.
  bit         m_pres [ENT];
  bit [19:0]  m_vpn  [ENT];
  bit [19:0]  m_pfn  [ENT];
  bit [7:0]   m_asid [ENT];
  bit         m_g [ENT], m_v [ENT], m_d [ENT];
  bit         e_vld [NCH];
  bit [31:0]  e_pa  [NCH];
  bit         e_unc [NCH], e_miss [NCH], e_inv [NCH], e_mod [NCH];

  task automatic model_clear();
    for (int e = 0; e < ENT; e++) m_pres[e] = 0;
    for (int c = 0; c < NCH; c++) begin
      e_vld[c] = 0; e_pa[c] = 0; e_unc[c] = 0; e_miss[c] = 0; e_inv[c] = 0; e_mod[c] = 0;
    end
  endtask

  task automatic lookup(input bit [31:0] va, input bit st, output bit [31:0] pa,
                        output bit unc, output bit miss, output bit inv, output bit mod);
    bit found = 0;
    pa = 0; unc = 0; miss = 0; inv = 0; mod = 0;
    if (va[31:30] == 2'b10) begin
      pa  = va & 32'h1FFF_FFFF;
      unc = va[29];
    end else begin
      for (int e = 0; e < ENT; e++) begin
        if (!found && m_pres[e] && m_vpn[e] == va[31:12] && (m_g[e] || m_asid[e] == cur_asid)) begin
          found = 1;
          pa  = {m_pfn[e], va[11:0]};
          inv = !m_v[e];
          mod = m_v[e] && st && !m_d[e];
        end
      end
      miss = !found;
    end
  endtask

  task automatic idle();
    rst = 0; cur_asid = 8'd5; req_valid = '0; req_store = '0; req_vaddr = '0;
    resp_ready = '1; tlbw_en = 0; tlbw_idx = '0; tlbw_vpn = '0; tlbw_pfn = '0;
    tlbw_asid = '0; tlbw_g = 0; tlbw_v = 0; tlbw_d = 0; tlb_flush = 0;
  endtask

  // Inputs are already driven; check ready, predict the edge, then check outputs after it.
  task automatic cycle();
    bit [31:0] pa;
    bit unc, miss, inv, mod;
    #1;
    for (int c = 0; c < NCH; c++)
      check($sformatf("rdy%0d", c), {31'b0, req_ready[c]}, {31'b0, !e_vld[c] || resp_ready[c]});
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        e_vld[c] = 0; e_pa[c] = 0; e_unc[c] = 0; e_miss[c] = 0; e_inv[c] = 0; e_mod[c] = 0;
      end else if (req_valid[c] && (!e_vld[c] || resp_ready[c])) begin
        lookup(req_vaddr[32*c +: 32], req_store[c], pa, unc, miss, inv, mod);
        e_vld[c] = 1; e_pa[c] = pa; e_unc[c] = unc; e_miss[c] = miss; e_inv[c] = inv; e_mod[c] = mod;
      end else if (resp_ready[c]) begin
        e_vld[c] = 0;
      end
    end
    if (rst) begin
      for (int e = 0; e < ENT; e++) m_pres[e] = 0;
    end else begin
      if (tlb_flush) for (int e = 0; e < ENT; e++) m_pres[e] = 0;
      if (tlbw_en) begin
        m_pres[tlbw_idx] = 1; m_vpn[tlbw_idx] = tlbw_vpn; m_pfn[tlbw_idx] = tlbw_pfn;
        m_asid[tlbw_idx] = tlbw_asid; m_g[tlbw_idx] = tlbw_g; m_v[tlbw_idx] = tlbw_v;
        m_d[tlbw_idx] = tlbw_d;
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("vld%0d", c), {31'b0, resp_valid[c]}, {31'b0, e_vld[c]});
      if (e_vld[c]) begin
        check($sformatf("pa%0d", c), resp_paddr[32*c +: 32], e_pa[c]);
        check($sformatf("flags%0d", c),
              {28'b0, resp_uncached[c], resp_miss[c], resp_inv[c], resp_mod[c]},
              {28'b0, e_unc[c], e_miss[c], e_inv[c], e_mod[c]});
      end
    end
  endtask

  task automatic tlb_write(input int idx, input bit [19:0] vpn, input bit [19:0] pfn,
                           input bit [7:0] asid, input bit g, input bit v, input bit d);
    tlbw_en = 1; tlbw_idx = idx[IDXW-1:0]; tlbw_vpn = vpn; tlbw_pfn = pfn;
    tlbw_asid = asid; tlbw_g = g; tlbw_v = v; tlbw_d = d;
  endtask

  bit [19:0] vpn_pool [6] = '{20'h00400, 20'h00500, 20'h00600, 20'hC0001, 20'hE0002, 20'h7FFFF};

  task automatic rand_inputs();
    rst       = ($urandom_range(0, 199) == 0);
    cur_asid  = 8'($urandom_range(5, 6));
    tlb_flush = ($urandom_range(0, 49) == 0);
    tlbw_en   = ($urandom_range(0, 4) == 0);
    tlbw_idx  = IDXW'($urandom_range(0, ENT - 1));
    tlbw_vpn  = vpn_pool[$urandom_range(0, 5)];
    tlbw_pfn  = 20'($urandom);
    tlbw_asid = 8'($urandom_range(5, 6));
    tlbw_g = 1'($urandom); tlbw_v = 1'($urandom); tlbw_d = 1'($urandom);
    for (int c = 0; c < NCH; c++) begin
      req_valid[c]  = ($urandom_range(0, 3) != 0);
      resp_ready[c] = ($urandom_range(0, 9) < 7);
      req_store[c]  = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       req_vaddr[32*c +: 32] = {3'b100, 29'($urandom)};
        1:       req_vaddr[32*c +: 32] = {3'b101, 29'($urandom)};
        default: req_vaddr[32*c +: 32] = {vpn_pool[$urandom_range(0, 5)], 12'($urandom)};
      endcase
    end
  endtask

  logic [31:0] held_pa;

  initial begin
    idle();
    model_clear();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", {30'b0, resp_valid}, 32'd0);
    check("rst_rdy", {30'b0, req_ready}, 32'd3);
    check("rst_pa0", resp_paddr[31:0], 32'd0);
    check("rst_flags", {24'b0, resp_uncached, resp_miss, resp_inv, resp_mod}, 32'd0);
    rst = 0;

    // kseg1 direct map
    req_valid = 2'b01; req_vaddr[31:0] = 32'hBFC0_0000;
    cycle();
    check("t1_pa", resp_paddr[31:0], 32'h1FC0_0000);
    check("t1_unc", {31'b0, resp_uncached[0]}, 32'd1);

    // ASID-matched store to a clean page, then ASID mismatch
    idle(); tlb_write(3, 20'h00400, 20'h12345, 8'd5, 0, 1, 0);
    cycle();
    idle(); req_valid = 2'b10; req_store = 2'b10; req_vaddr[63:32] = 32'h0040_0ABC;
    cycle();
    check("t2_pa", resp_paddr[63:32], 32'h1234_5ABC);
    check("t2_mod", {31'b0, resp_mod[1]}, 32'd1);
    cur_asid = 8'd6;
    cycle();
    check("t2_miss", {31'b0, resp_miss[1]}, 32'd1);

    // ch0 stalled three cycles while ch1 streams
    idle(); req_valid = 2'b11; resp_ready = 2'b10; req_vaddr[31:0] = 32'h8000_1234;
    req_vaddr[63:32] = 32'h8000_0000;
    cycle();
    held_pa = resp_paddr[31:0];
    check("t3_pa0", held_pa, 32'h0000_1234);
    for (int k = 1; k <= 3; k++) begin
      req_vaddr[31:0]  = 32'h8000_5678;
      req_vaddr[63:32] = 32'h8000_0000 + 32'(k * 16);
      cycle();
      check("t3_rdy0", {31'b0, req_ready[0]}, 32'd0);
      check("t3_hold", resp_paddr[31:0], 32'h0000_1234);
      check("t3_ch1", resp_paddr[63:32], 32'(k * 16));
    end

    // write and lookup in the same cycle see the old contents
    idle(); tlb_write(5, 20'h00500, 20'h0ABCD, 8'd0, 1, 1, 1);
    req_valid = 2'b01; req_vaddr[31:0] = 32'h0050_0123;
    cycle();
    check("t4_miss", {31'b0, resp_miss[0]}, 32'd1);
    tlbw_en = 0;
    cycle();
    check("t4_hit", resp_paddr[31:0], 32'h0ABC_D123);

    // duplicate vpn: lowest index wins; flush clears
    idle(); tlb_write(9, 20'h00700, 20'hBBBBB, 8'd0, 1, 1, 1);
    cycle();
    tlb_write(2, 20'h00700, 20'hAAAAA, 8'd0, 1, 1, 1);
    cycle();
    idle(); req_valid = 2'b01; req_vaddr[31:0] = 32'h0070_0456;
    cycle();
    check("t5_low", resp_paddr[31:0], 32'hAAAA_A456);
    idle(); tlb_flush = 1;
    cycle();
    idle(); req_valid = 2'b01; req_vaddr[31:0] = 32'h0070_0456;
    cycle();
    check("t5_flush", {31'b0, resp_miss[0]}, 32'd1);

    // reset while a response is held
    idle(); tlb_write(3, 20'h00400, 20'h12345, 8'd5, 1, 1, 1);
    cycle();
    idle(); req_valid = 2'b01; resp_ready = 2'b00; req_vaddr[31:0] = 32'h8000_0040;
    cycle();
    check("t6_held", {31'b0, resp_valid[0]}, 32'd1);
    rst = 1;
    cycle();
    check("t6_vld", {31'b0, resp_valid[0]}, 32'd0);
    idle(); req_valid = 2'b01; req_vaddr[31:0] = 32'h0040_0ABC;
    cycle();
    check("t6_miss", {31'b0, resp_miss[0]}, 32'd1);

    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
